// File: rtl/window_deserializer_pkg.sv
// Shared definitions for the window deserializer: sync marker, header field
// positions and the frame state encoding.
package window_deserializer_pkg;

    // Marker carried in the top byte of every header beat.
    localparam logic [7:0] SYNC_MARKER = 8'hA5;

    // Header field positions: the marker sits in the top MARKER_W bits of the
    // beat, metadata sits at the bottom starting at META_LSB.
    localparam int MARKER_W = 8;
    localparam int META_LSB = 0;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        OUT     = 2'd2
    } state_e;

endpackage

// File: rtl/window_deserializer.sv
// Window deserializer: reassembles a header-tagged stream of BUS_WIDTH beats
// into one WINDOW_WIDTH window (LSB-first) with its metadata tag.
// Optional feature: define WINDOW_DESERIALIZER_ERR_CNT_EN to add a saturating
// 16-bit count of rejected headers on err_count.
module window_deserializer
    import window_deserializer_pkg::*;
#(
    parameter int WINDOW_WIDTH = 1152,
    parameter int BUS_WIDTH    = 128,
    parameter int META_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    stream,
    input  logic                    stream_valid,
    output logic                    stream_ready,
    output logic [WINDOW_WIDTH-1:0] window,
    output logic [META_WIDTH-1:0]   metadata,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic                    frame_err
`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    localparam int BEATS = (WINDOW_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    // A single-beat window still needs a one-bit counter to stay legal.
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [META_WIDTH-1:0]   meta_q, meta_d;
    logic                    frame_err_q, frame_err_d;
    logic [WINDOW_WIDTH-1:0] window_q, window_d;
    logic [BEATS-1:0]        slot_we;
    logic                    accept;
    logic                    marker_ok;

    assign accept    = stream_valid && stream_ready;
    assign marker_ok = (stream[BUS_WIDTH-1 -: MARKER_W] == SYNC_MARKER);

    // Next-state, counter, metadata capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        meta_d       = meta_q;
        frame_err_d  = 1'b0;
        stream_ready = 1'b0;
        window_valid = 1'b0;
        case (state_q)
            HDR: begin
                stream_ready = 1'b1;
                if (accept) begin
                    if (marker_ok) begin
                        meta_d  = stream[META_LSB +: META_WIDTH];
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                // No marker check here: a payload beat that looks like a
                // header is plain data.
                stream_ready = 1'b1;
                if (accept) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                window_valid = 1'b1;
                if (window_ready) begin
                    state_d = HDR;
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    // Per-slot write: beat k lands at window[k*BUS_WIDTH +: BUS_WIDTH]; the
    // last slot is trimmed so bits beyond WINDOW_WIDTH are dropped.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
        localparam int LO = gi * BUS_WIDTH;
        localparam int SW = ((WINDOW_WIDTH - LO) < BUS_WIDTH) ? (WINDOW_WIDTH - LO) : BUS_WIDTH;
        assign slot_we[gi] = (state_q == PAYLOAD) && accept && (cnt_q == CNT_W'(gi));
        assign window_d[LO +: SW] = slot_we[gi] ? stream[SW-1:0] : window_q[LO +: SW];
    end

    // State, counter, metadata, error pulse and window registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            cnt_q       <= '0;
            meta_q      <= '0;
            frame_err_q <= 1'b0;
            window_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            meta_q      <= meta_d;
            frame_err_q <= frame_err_d;
            window_q    <= window_d;
        end
    end

    assign window    = window_q;
    assign metadata  = meta_q;
    assign frame_err = frame_err_q;

`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
    logic [15:0] err_count_q;

    // Saturating count of rejected headers, one step per frame_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (frame_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_window_deserializer.sv
// Self-checking bench for window_deserializer at default parameters.
// Expected windows are queued when a frame is driven and popped when the DUT
// presents its window.
module tb_window_deserializer;

    localparam int WW    = 1152;
    localparam int BW    = 128;
    localparam int MW    = 3;
    localparam int BEATS = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] stream;
    logic          stream_valid;
    logic          stream_ready;
    logic [WW-1:0] window;
    logic [MW-1:0] metadata;
    logic          window_valid;
    logic          window_ready;
    logic          frame_err;
`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    window_deserializer #(
        .WINDOW_WIDTH(WW),
        .BUS_WIDTH   (BW),
        .META_WIDTH  (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stream      (stream),
        .stream_valid(stream_valid),
        .stream_ready(stream_ready),
        .window      (window),
        .metadata    (metadata),
        .window_valid(window_valid),
        .window_ready(window_ready),
        .frame_err   (frame_err)
`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [WW-1:0] win;
        logic [MW-1:0] meta;
    } exp_t;
    exp_t sb[$];

    function automatic logic [BW-1:0] beat_val(input int k, input int seed);
        logic [7:0] b;
        b = 8'(k + seed);
        return {16{b}};
    endfunction

    // Drive one beat from a negedge; returns on the negedge after acceptance.
    task automatic send_beat(input logic [BW-1:0] d);
        int n;
        n = 0;
        stream       = d;
        stream_valid = 1'b1;
        while (stream_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_beat_timeout: stream_ready=%b after %0d cycles, required 1", stream_ready, n);
        end
        @(negedge clk);
        stream_valid = 1'b0;
        stream       = '0;
    endtask

    task automatic send_header(input logic [MW-1:0] meta, input bit good);
        logic [BW-1:0] h;
        h = '0;
        h[BW-1 -: 8] = good ? 8'hA5 : 8'h5A;
        h[MW-1:0]    = meta;
        send_beat(h);
    endtask

    task automatic send_frame(input logic [MW-1:0] meta, input int seed, input int gap);
        exp_t e;
        e.win  = '0;
        e.meta = meta;
        for (int k = 0; k < BEATS; k++) e.win[k*BW +: BW] = beat_val(k, seed);
        sb.push_back(e);
        send_header(meta, 1'b1);
        for (int k = 0; k < BEATS; k++) begin
            send_beat(beat_val(k, seed));
            if (gap > 0 && k < BEATS - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_window(input string name);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s_sb_empty: window_valid=%b with no expected window queued", name, window_valid);
        end else begin
            e = sb.pop_front();
            if (window !== e.win) begin
                n_bad++;
                $display("FAIL %s_window: got low=%h high=%h, required low=%h high=%h",
                         name, window[127:0], window[WW-1 -: 128], e.win[127:0], e.win[WW-1 -: 128]);
            end
            n_cmp++;
            if (metadata !== e.meta) begin
                n_bad++;
                $display("FAIL %s_meta: got %0d, required %0d", name, metadata, e.meta);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stream = '0; stream_valid = 1'b0; window_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (window_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: window_valid=%b frame_err=%b, required 0 0", window_valid, frame_err);
        end
        n_cmp++;
        if (window !== '0 || metadata !== '0) begin
            n_bad++;
            $display("FAIL reset_data: window_low=%h metadata=%0d, required 0 0", window[127:0], metadata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stream_ready !== 1'b1 || window_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: stream_ready=%b window_valid=%b, required 1 0", stream_ready, window_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int t0;
        window_ready = 1'b1;
        t0 = cycle;
        send_frame(3'd5, 0, 0);
        n_cmp++;
        if (window_valid !== 1'b1 || (cycle - t0) != BEATS + 1) begin
            n_bad++;
            $display("FAIL nominal_latency: window_valid=%b after %0d cycles, required 1 after %0d",
                     window_valid, cycle - t0, BEATS + 1);
        end
        n_cmp++;
        if (window[127:0] !== {16{8'h00}} || window[1151:1024] !== {16{8'h08}}) begin
            n_bad++;
            $display("FAIL nominal_slices: low=%h high=%h, required all 00 / all 08", window[127:0], window[1151:1024]);
        end
        check_window("nominal");
        @(negedge clk);
        n_cmp++;
        if (stream_ready !== 1'b1 || window_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_return: stream_ready=%b window_valid=%b, required 1 0", stream_ready, window_valid);
        end
        $display("test_nominal: meta=5 window checked");
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        window_ready = 1'b1;
        send_frame(3'd1, 8'h40, 0);
        t1 = cycle;
        check_window("b2b_first");
        send_frame(3'd6, 8'h80, 0);
        t2 = cycle;
        n_cmp++;
        if (window_valid !== 1'b1 || (t2 - t1) != BEATS + 2) begin
            n_bad++;
            $display("FAIL b2b_throughput: window_valid=%b interval=%0d, required 1 %0d", window_valid, t2 - t1, BEATS + 2);
        end
        check_window("b2b_second");
        @(negedge clk);
        $display("test_back_to_back: interval %0d cycles", t2 - t1);
    endtask

    task automatic test_bad_header();
        window_ready = 1'b1;
        send_header(3'd3, 1'b0);
        n_cmp++;
        if (frame_err !== 1'b1 || window_valid !== 1'b0 || stream_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_hdr_pulse: frame_err=%b window_valid=%b stream_ready=%b, required 1 0 1",
                     frame_err, window_valid, stream_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_hdr_width: frame_err=%b on second cycle, required 0", frame_err);
        end
        send_frame(3'd3, 8'h10, 0);
        n_cmp++;
        if (window_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_hdr_recover: window_valid=%b, required 1", window_valid);
        end
        check_window("bad_hdr_good_frame");
        @(negedge clk);
        $display("test_bad_header done");
    endtask

    task automatic test_gaps();
        int t0;
        window_ready = 1'b1;
        t0 = cycle;
        send_frame(3'd5, 0, 1);
        n_cmp++;
        if (window_valid !== 1'b1 || (cycle - t0) != BEATS + 1 + (BEATS - 1)) begin
            n_bad++;
            $display("FAIL gaps_latency: window_valid=%b after %0d cycles, required 1 after %0d",
                     window_valid, cycle - t0, BEATS + 1 + (BEATS - 1));
        end
        check_window("gaps");
        @(negedge clk);
        $display("test_gaps: %0d gap cycles", BEATS - 1);
    endtask

    task automatic test_backpressure();
        exp_t e;
        window_ready = 1'b0;
        send_frame(3'd2, 8'h30, 0);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (window_valid !== 1'b1 || stream_ready !== 1'b0 || window !== e.win || metadata !== e.meta) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: window_valid=%b stream_ready=%b meta=%0d window_low=%h, required 1 0 %0d %h",
                         i, window_valid, stream_ready, metadata, window[127:0], e.meta, e.win[127:0]);
            end
            if (i < 4) @(negedge clk);
        end
        window_ready = 1'b1;
        check_window("bp");
        @(negedge clk);
        n_cmp++;
        if (stream_ready !== 1'b1 || window_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: stream_ready=%b window_valid=%b, required 1 0", stream_ready, window_valid);
        end
        $display("test_backpressure: held 5 cycles");
    endtask

    task automatic test_reset_mid();
        int seen;
        window_ready = 1'b1;
        send_header(3'd7, 1'b1);
        for (int k = 0; k < 4; k++) send_beat(beat_val(k, 8'h50));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (window_valid !== 1'b0 || window !== '0 || metadata !== '0 || stream_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_state: window_valid=%b meta=%0d window_low=%h stream_ready=%b, required 0 0 0 1",
                     window_valid, metadata, window[127:0], stream_ready);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (window_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midrst_no_window: window_valid high %0d cycles, required 0", seen);
        end
        send_frame(3'd4, 8'h60, 0);
        n_cmp++;
        if (window_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_new_frame: window_valid=%b, required 1", window_valid);
        end
        check_window("midrst");
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
    task automatic test_err_count();
        window_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) send_header(3'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err_count !== 16'd3) begin
            n_bad++;
            $display("FAIL err_count_three: got %0d, required 3", err_count);
        end
        dut.err_count_q = 16'hFFFE;
        repeat (3) send_header(3'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL err_count_sat: got %h, required ffff", err_count);
        end
        $display("test_err_count done");
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_bad_header();
        test_gaps();
        test_backpressure();
        test_reset_mid();
`ifdef WINDOW_DESERIALIZER_ERR_CNT_EN
        test_err_count();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d windows outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_deserializer.md
WINDOW_DESERIALIZER -- requirements
Module: window_deserializer

Interface
REQ-001 The module SHALL have parameter WINDOW_WIDTH, default 1152, the reassembled window width in bits.
REQ-002 The module SHALL have parameter BUS_WIDTH, default 128, the stream beat width in bits.
REQ-003 The module SHALL have parameter META_WIDTH, default 3, the pyramid-level metadata width.
REQ-004 Ports SHALL be, in order:
- clk  input  1  sole clock.
- rst  input  1  reset; synchronous, active-high.
- stream  input  BUS_WIDTH  incoming beat.
- stream_valid  input  1  beat valid.
- stream_ready  output  1  beat accepted when high with stream_valid.
- window  output  WINDOW_WIDTH  reassembled window.
- metadata  output  META_WIDTH  level tag of the current window.
- window_valid  output  1  window and metadata valid.
- window_ready  input  1  downstream accepts the window.
- frame_err  output  1  one-cycle pulse when a header is rejected.
- err_count  output  16  rejected-header count; present only with the REQ-018 macro.

Function
REQ-005 The module SHALL treat BEATS = ceil(WINDOW_WIDTH/BUS_WIDTH) as the payload length, which is 9 at default parameters.
REQ-006 A frame SHALL be one header beat followed by BEATS payload beats.
- Header layout: bits [BUS_WIDTH-1 -: 8] hold sync marker 8'hA5; bits [META_WIDTH-1:0] hold metadata; all other bits are ignored.
REQ-007 Payload SHALL be LSB-first: payload beat k maps to window[k*BUS_WIDTH +: BUS_WIDTH].
- In the last beat, bits beyond WINDOW_WIDTH are discarded.
REQ-008 A beat SHALL transfer only on a cycle where stream_valid && stream_ready.
- Cycles with stream_valid low SHALL change no state.
REQ-009 The state machine SHALL have three states: HDR, PAYLOAD and OUT.
- HDR: stream_ready = 1. An accepted beat with the correct marker latches metadata, clears the beat counter and moves to PAYLOAD. An accepted beat with a wrong marker is dropped, pulses frame_err for exactly 1 cycle, and stays in HDR.
- PAYLOAD: stream_ready = 1. Each accepted beat is written to its slot and increments the counter. Acceptance of beat BEATS-1 moves to OUT.
- OUT: stream_ready = 0 and window_valid = 1. When window_ready is high, move to HDR.
REQ-010 window_valid SHALL assert on the cycle after the last payload beat is accepted, which is 1-cycle latency.
REQ-011 window and metadata SHALL hold stable while window_valid is high and window_ready is low, for any number of cycles.
REQ-012 Sustained throughput SHALL be BEATS+2 cycles per window when window_ready is held high.
REQ-013 The beat counter SHALL be $clog2(BEATS) bits wide and SHALL never exceed BEATS-1.
REQ-014 The module SHALL perform no marker check in PAYLOAD; a payload beat equal to 8'hA5 in its top bits is data.

Reset
REQ-015 On reset:
- state = HDR;
- beat counter = 0;
- window = 0 and metadata = 0;
- window_valid = 0 and frame_err = 0;
- err_count = 0;
- stream_ready = 1 from the first cycle after reset deasserts.
REQ-016 Reset asserted mid-PAYLOAD or in OUT SHALL discard the partial or pending window without emitting it.

Configuration
REQ-017 Without the REQ-018 macro, the err_count port and its logic SHALL be absent.
REQ-018 With macro WINDOW_DESERIALIZER_ERR_CNT_EN defined, err_count SHALL increment on each frame_err pulse and saturate at 16'hFFFF.

Structure
REQ-019 The HOG shared package SHALL hold:
- SYNC_MARKER = 8'hA5;
- the header field positions;
- the state enum.
REQ-020 The block SHALL be a single module with no sub-module; the beat counter and window register are inline.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Nominal frame: header {8'hA5, …, meta=3'd5}, then 9 beats where beat k = {16{k[7:0]}}, with window_ready held 1 → window_valid 1 cycle after beat 8 is accepted, window[127:0] = {16{8'h00}}, window[1151:1024] = {16{8'h08}}, metadata = 5.
- Backpressure: window_ready held 0 for 5 cycles after window_valid → window and metadata stable, stream_ready = 0 for all 5 cycles, HDR re-entered the cycle after window_ready = 1.
- Bad header: top byte 8'h5A, then a good frame → frame_err high exactly 1 cycle, no window from the bad beat, the good frame decodes correctly.
- Valid gaps: stream_valid toggled 1/0 through the payload → same window as nominal, latency stretched by the number of gap cycles.
- Reset mid-frame: rst pulsed after 4 payload beats, then a full new frame → no window_valid for the aborted frame, the new frame is output intact.
- With WINDOW_DESERIALIZER_ERR_CNT_EN: 3 bad headers → err_count = 3; counter preset near saturation → err_count holds at 16'hFFFF.
